// File: rtl/cmd_decoder_ctrl.sv
// Purpose: validate command words, update per-channel enable/level, run req/ack transfers with timeout.
// Latency: accept at T, err at T+2, effects and cmd_done at T+3 (or after ack/timeout for transfers).
// Backpressure: in_ready only in IDLE; one word in flight, the source holds its word while in_ready=0.
module cmd_decoder_ctrl #(
    parameter int DATA_WIDTH   = 17,
    parameter int AMOUNT_WIDTH = 8,
    parameter int CH_W         = 2,
    parameter int NUM_CH       = 4,
    parameter int LEVEL_MAX    = 200,
    parameter int TIMEOUT      = 1000,
    parameter int ERR_W        = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_CH-1:0]              ch_en,
    output logic [NUM_CH*AMOUNT_WIDTH-1:0] level,
    output logic                           xfer_req,
    output logic                           xfer_dir,
    output logic [CH_W-1:0]                xfer_ch,
    input  logic                           xfer_ack,
    output logic                           cmd_done,
    output logic                           err,
    output logic                           timeout_flag,
    output logic [ERR_W-1:0]               err_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int AW    = AMOUNT_WIDTH;

    typedef enum logic [1:0] {IDLE, CHECK, APPLY, XFER} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_live;
    logic [DATA_WIDTH-1:0] r_cmd;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_CH-1:0]     r_ch_en;
    logic [AW-1:0]         r_level [NUM_CH];

    // Decoded fields of the latched command
    logic            w_on, w_off, w_inc, w_dec, w_recv, w_send, w_xfer;
    logic [CH_W-1:0] w_ch;
    logic [AW-1:0]   w_amt;
    logic            w_illegal;
    logic            w_ack_hit, w_expire;
    logic            w_done_nxt, w_err_nxt, w_req_nxt;
    logic            w_cur_en, w_en_new;
    logic [AW-1:0]   w_cur_lvl, w_lvl_new;
    logic [AW:0]     w_sum;

    assign w_on   = r_cmd[0];
    assign w_off  = r_cmd[1];
    assign w_inc  = r_cmd[2];
    assign w_dec  = r_cmd[3];
    assign w_recv = r_cmd[4];
    assign w_send = r_cmd[5];
    assign w_xfer = w_send | w_recv;
    assign w_ch   = r_cmd[7 +: CH_W];
    assign w_amt  = r_cmd[DATA_WIDTH-1 -: AW];

    // Even parity over the whole word, including bits no field uses
    assign w_illegal = (^r_cmd) | (w_on & w_off) | (w_inc & w_dec) | (w_send & w_recv)
                     | ({1'b0, w_ch} >= (CH_W+1)'(NUM_CH)) | (r_cmd[5:0] == 6'd0);

    // Ack on the expiry cycle wins, so expiry is qualified by no ack
    assign w_ack_hit = (r_state == XFER) & xfer_ack;
    assign w_expire  = (r_state == XFER) & ~xfer_ack & (r_cnt == CNT_W'(TIMEOUT - 1));

    // in_ready stays low while in reset and until the first clock after release
    assign in_ready = r_live & (r_state == IDLE);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid && in_ready) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = w_illegal ? IDLE : APPLY;
            APPLY:   w_state_nxt = w_xfer ? XFER : IDLE;
            XFER:    if (w_ack_hit || w_expire) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs: next values of the registered pulses and request
    always_comb begin
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_req_nxt  = 1'b0;
        case (r_state)
            CHECK: w_err_nxt = w_illegal;
            APPLY: begin
                w_done_nxt = ~w_xfer;
                w_req_nxt  = w_xfer;
            end
            XFER: begin
                w_done_nxt = w_ack_hit;
                w_err_nxt  = w_expire;
                w_req_nxt  = ~w_ack_hit & ~w_expire;
            end
            default: ;
        endcase
    end

    // Latch the accepted word and run the transfer wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd <= '0;
            r_cnt <= '0;
        end else begin
            if (in_valid && in_ready) r_cmd <= in_data;
            r_cnt <= (r_state == XFER) ? r_cnt + CNT_W'(1) : '0;
        end
    end

    // Registered status/transfer outputs and saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_done     <= 1'b0;
            err          <= 1'b0;
            xfer_req     <= 1'b0;
            xfer_dir     <= 1'b0;
            xfer_ch      <= '0;
            timeout_flag <= 1'b0;
            err_count    <= '0;
        end else begin
            cmd_done <= w_done_nxt;
            err      <= w_err_nxt;
            xfer_req <= w_req_nxt;
            if (r_state == APPLY && w_xfer) begin
                xfer_dir <= w_send;
                xfer_ch  <= w_ch;
            end
            if (w_expire) timeout_flag <= 1'b1;
            if (w_err_nxt && (err_count != {ERR_W{1'b1}})) err_count <= err_count + ERR_W'(1);
        end
    end

    // Select the addressed channel's current enable and level
    always_comb begin
        w_cur_en  = 1'b0;
        w_cur_lvl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == CH_W'(i)) begin
                w_cur_en  = r_ch_en[i];
                w_cur_lvl = r_level[i];
            end
        end
    end

    // Enable resolves first; inc/dec then act only on an enabled channel
    always_comb begin
        w_en_new  = w_on ? 1'b1 : (w_off ? 1'b0 : w_cur_en);
        w_sum     = {1'b0, w_cur_lvl} + {1'b0, w_amt};
        w_lvl_new = w_cur_lvl;
        if (w_en_new && w_inc)
            w_lvl_new = (w_sum > (AW+1)'(LEVEL_MAX)) ? AW'(LEVEL_MAX) : w_sum[AW-1:0];
        else if (w_en_new && w_dec)
            w_lvl_new = (w_cur_lvl >= w_amt) ? (w_cur_lvl - w_amt) : '0;
    end

    // Commit per-channel state in APPLY; level is kept across off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_en <= '0;
            for (int i = 0; i < NUM_CH; i++) r_level[i] <= '0;
        end else if (r_state == APPLY) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_ch == CH_W'(i)) begin
                    r_ch_en[i] <= w_en_new;
                    r_level[i] <= w_lvl_new;
                end
            end
        end
    end

    assign ch_en = r_ch_en;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_lvl
            assign level[g*AW +: AW] = r_level[g];
        end
    endgenerate

endmodule

// File: tb/tb_cmd_decoder_ctrl.sv
// Directed bench for cmd_decoder_ctrl with NUM_CH=3, TIMEOUT=16.
// Checks reset, field decode, saturation, rejects, transfer ack/timeout and back-to-back throughput.
module tb_cmd_decoder_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [16:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  ch_en;
    logic [23:0] level;
    logic        xfer_req, xfer_dir, xfer_ack = 1'b0;
    logic [1:0]  xfer_ch;
    logic        cmd_done, err, timeout_flag;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    cmd_decoder_ctrl #(
        .DATA_WIDTH(17), .AMOUNT_WIDTH(8), .CH_W(2), .NUM_CH(3),
        .LEVEL_MAX(200), .TIMEOUT(16), .ERR_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ch_en(ch_en), .level(level), .xfer_req(xfer_req), .xfer_dir(xfer_dir), .xfer_ch(xfer_ch),
        .xfer_ack(xfer_ack), .cmd_done(cmd_done), .err(err), .timeout_flag(timeout_flag),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ops = {send,recv,dec,inc,off,on}; bad=1 flips the parity bit
    function automatic logic [16:0] mk(input logic [5:0] ops, input int ch, input int amt, input bit bad);
        logic [16:0] w;
        w       = '0;
        w[5:0]  = ops;
        w[8:7]  = ch[1:0];
        w[16:9] = amt[7:0];
        w[6]    = (^w) ^ bad;
        return w;
    endfunction

    // Present a word and complete the handshake; returns in cycle T+1
    task automatic issue(input logic [16:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", in_ready, 1'b1);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic to_t3();
        @(negedge clk);  // T+1
        chk("t1_no_err", err, 1'b0);
        @(negedge clk);  // T+2
        @(negedge clk);  // T+3
    endtask

    initial begin
        int n;
        int hs [3];
        int cyc;
        int idx;
        int dones;
        logic [16:0] bw [3];

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_ch_en", ch_en, 3'b000);
        chk("rst_level", level, 24'h0);
        chk("rst_err_count", err_count, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1'b1);

        // on+inc 50 on ch2
        issue(mk(6'b000101, 2, 50, 0));
        @(negedge clk);
        @(negedge clk);
        chk("inc50_t2_done", cmd_done, 1'b0);
        @(negedge clk);
        chk("inc50_done", cmd_done, 1'b1);
        chk("inc50_en", ch_en, 3'b100);
        chk("inc50_lvl", level[16 +: 8], 8'd50);
        chk("inc50_ready", in_ready, 1'b1);

        // dec 70 below zero clamps
        issue(mk(6'b001000, 2, 70, 0));
        to_t3();
        chk("dec70_lvl", level[16 +: 8], 8'd0);
        chk("dec70_done", cmd_done, 1'b1);

        // inc 60 then inc 180 saturates at 200
        issue(mk(6'b000100, 2, 60, 0));
        to_t3();
        chk("inc60_lvl", level[16 +: 8], 8'd60);
        issue(mk(6'b000100, 2, 180, 0));
        to_t3();
        chk("inc180_sat", level[16 +: 8], 8'd200);

        // inc on disabled ch0: ignored, still completes
        issue(mk(6'b000100, 0, 10, 0));
        @(negedge clk);
        @(negedge clk);
        chk("dis_t2_err", err, 1'b0);
        @(negedge clk);
        chk("dis_done", cmd_done, 1'b1);
        chk("dis_err", err, 1'b0);
        chk("dis_lvl0", level[0 +: 8], 8'd0);

        // Rejected words: bad parity, on&off, channel 3, no op bits
        issue(mk(6'b000001, 1, 0, 1));
        to_t3();
        issue(mk(6'b000011, 1, 0, 0));
        to_t3();
        issue(mk(6'b000101, 3, 9, 0));
        to_t3();
        issue(mk(6'b000000, 1, 5, 0));
        @(negedge clk);
        @(negedge clk);
        chk("rej_err_pulse", err, 1'b1);
        chk("rej_err_done", cmd_done, 1'b0);
        chk("rej_count4", err_count, 8'd4);
        @(negedge clk);
        chk("rej_err_clear", err, 1'b0);
        chk("rej_no_done", cmd_done, 1'b0);
        chk("rej_en_kept", ch_en, 3'b100);
        chk("rej_lvl_kept", level, {8'd200, 8'd0, 8'd0});

        // send on ch1, ack in the 5th request cycle
        issue(mk(6'b100000, 1, 0, 0));
        to_t3();
        chk("send_dir", xfer_dir, 1'b1);
        chk("send_ch", xfer_ch, 2'd1);
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            chk("send_req_hi", xfer_req, 1'b1);
            if (k == 5) xfer_ack = 1'b1;
        end
        @(negedge clk);
        xfer_ack = 1'b0;
        chk("send_req_lo", xfer_req, 1'b0);
        chk("send_done", cmd_done, 1'b1);
        chk("send_no_err", err, 1'b0);

        // recv on ch2 with no ack times out after 16 request cycles
        issue(mk(6'b010000, 2, 0, 0));
        to_t3();
        chk("recv_dir", xfer_dir, 1'b0);
        chk("recv_ch", xfer_ch, 2'd2);
        n = 0;
        while (xfer_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("recv_req_cycles", n, 16);
        chk("recv_err", err, 1'b1);
        chk("recv_no_done", cmd_done, 1'b0);
        chk("recv_tflag", timeout_flag, 1'b1);
        chk("recv_count5", err_count, 8'd5);

        // Ack on the expiry cycle: ack wins
        issue(mk(6'b100000, 0, 0, 0));
        to_t3();
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 16) begin
                chk("edge_req_hi", xfer_req, 1'b1);
                xfer_ack = 1'b1;
            end
        end
        @(negedge clk);
        xfer_ack = 1'b0;
        chk("edge_req_lo", xfer_req, 1'b0);
        chk("edge_done", cmd_done, 1'b1);
        chk("edge_no_err", err, 1'b0);
        chk("edge_count", err_count, 8'd5);
        chk("edge_tflag_sticky", timeout_flag, 1'b1);

        // Back-to-back with in_valid held: on ch0, inc 5, inc 7
        bw[0] = mk(6'b000001, 0, 0, 0);
        bw[1] = mk(6'b000100, 0, 5, 0);
        bw[2] = mk(6'b000100, 0, 7, 0);
        @(negedge clk);
        in_data  = bw[0];
        in_valid = 1'b1;
        idx   = 0;
        cyc   = 0;
        dones = 0;
        while (idx < 3 && cyc < 40) begin
            if (cmd_done) dones++;
            if (in_ready) begin
                hs[idx] = cyc;
                @(posedge clk);
                #1;
                idx++;
                if (idx == 3) in_valid = 1'b0;
                else in_data = bw[idx];
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b_all_accepted", idx, 3);
        repeat (4) begin
            if (cmd_done) dones++;
            @(negedge clk);
        end
        chk("b2b_gap01", hs[1] - hs[0], 3);
        chk("b2b_gap12", hs[2] - hs[1], 3);
        chk("b2b_dones", dones, 3);
        chk("b2b_en", ch_en, 3'b101);
        chk("b2b_lvl0", level[0 +: 8], 8'd12);

        // Reset in the middle of a transfer
        issue(mk(6'b100000, 1, 0, 0));
        to_t3();
        chk("mid_req_hi", xfer_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_req", xfer_req, 1'b0);
        chk("mid_in_ready", in_ready, 1'b0);
        chk("mid_en", ch_en, 3'b000);
        chk("mid_level", level, 24'h0);
        chk("mid_tflag", timeout_flag, 1'b0);
        chk("mid_count", err_count, 8'd0);
        chk("mid_pulses", {cmd_done, err}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", in_ready, 1'b1);
        chk("mid_rel_req", xfer_req, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
